// File: rtl/suma_aritmetica.sv
// ---------------------------------------------------------------------------
// suma_aritmetica
// Registered unsigned adder for the calculator datapath. On every rising clk
// edge where suma_btn is high, num1 + num2 is captured (full carry kept,
// ANCHO+1 bits). The captured value is held until the next capture or reset.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   num1, num2    in   ANCHO-bit unsigned operands
//   suma_btn      in   add command, level sampled (debounced upstream)
//   resultado     out  ANCHO+1-bit registered sum
//   listo         out  high for each cycle in which resultado was just updated
//   resultado_bcd out  (only with SUMA_BCD_EN) four BCD digits of resultado,
//                      registered together with resultado
//
// Optional feature macro: SUMA_BCD_EN
// ---------------------------------------------------------------------------
module suma_aritmetica #(
    parameter int ANCHO = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ANCHO-1:0] num1,
    input  logic [ANCHO-1:0] num2,
    input  logic             suma_btn,
    output logic [ANCHO:0]   resultado,
    output logic             listo
`ifdef SUMA_BCD_EN
    ,
    output logic [15:0]      resultado_bcd
`endif
);

    logic [ANCHO:0] resultado_d, resultado_q;
    logic           listo_d, listo_q;

    always_comb begin
        resultado_d = resultado_q;
        listo_d     = 1'b0;
        if (suma_btn) begin
            // Zero-extend both operands so the carry lands in the top bit.
            resultado_d = {1'b0, num1} + {1'b0, num2};
            listo_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resultado_q <= '0;
            listo_q     <= 1'b0;
        end else begin
            resultado_q <= resultado_d;
            listo_q     <= listo_d;
        end
    end

    assign resultado = resultado_q;
    assign listo     = listo_q;

`ifdef SUMA_BCD_EN
    // Double-dabble. Digits shifted out of the top of the 16-bit window are
    // dropped, so wider sums yield their low four decimal digits.
    function automatic logic [15:0] bin2bcd(input logic [ANCHO:0] bin);
        logic [15:0] bcd;
        bcd = '0;
        for (int i = ANCHO; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (bcd[4*d +: 4] >= 4'd5)
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
            bcd = {bcd[14:0], bin[i]};
        end
        return bcd;
    endfunction

    logic [15:0] bcd_d, bcd_q;

    // Convert the next-state value so the BCD copy shares resultado's latency.
    always_comb begin
        bcd_d = bin2bcd(resultado_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bcd_q <= '0;
        else     bcd_q <= bcd_d;
    end

    assign resultado_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_suma_aritmetica.sv
module tb_suma_aritmetica;

    localparam int ANCHO = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic [ANCHO-1:0] num1, num2;
    logic             suma_btn;
    logic [ANCHO:0]   resultado;
    logic             listo;
`ifdef SUMA_BCD_EN
    logic [15:0]      resultado_bcd;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: last captured sum and last-cycle capture flag.
    int exp_res   = 0;
    int exp_listo = 0;

    suma_aritmetica #(.ANCHO(ANCHO)) dut (
        .clk       (clk),
        .rst       (rst),
        .num1      (num1),
        .num2      (num2),
        .suma_btn  (suma_btn),
        .resultado (resultado),
        .listo     (listo)
`ifdef SUMA_BCD_EN
        ,
        .resultado_bcd (resultado_bcd)
`endif
    );

    always #5 clk = ~clk;

    function automatic int to_bcd(input int v);
        return (v % 10) + ((v / 10) % 10) * 16 + ((v / 100) % 10) * 256
             + ((v / 1000) % 10) * 4096;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".resultado"}, int'(resultado), exp_res);
        check({tag, ".listo"}, int'(listo), exp_listo);
`ifdef SUMA_BCD_EN
        check({tag, ".bcd"}, int'(resultado_bcd), to_bcd(exp_res));
`endif
    endtask

    // Drive one cycle's inputs, let the edge happen, update the model, check.
    task automatic cycle(input string tag, input int a, input int b, input bit btn);
        num1     = ANCHO'(a);
        num2     = ANCHO'(b);
        suma_btn = btn;
        @(posedge clk);
        #1;
        if (btn) begin
            exp_res   = a + b;
            exp_listo = 1;
        end else begin
            exp_listo = 0;
        end
        check_outputs(tag);
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        #1;
        exp_res   = 0;
        exp_listo = 0;
    endtask

    initial begin
        // Reset with nonzero operands and the button pressed.
        num1 = 12'd123; num2 = 12'd456; suma_btn = 1'b1;
        assert_reset();
        #2 check_outputs("reset_async");
        @(posedge clk); #1 check_outputs("reset_held");
        @(posedge clk); #1 check_outputs("reset_held2");
        suma_btn = 1'b0;
        rst = 1'b0;
        cycle("idle", 7, 8, 0);

        cycle("999+999", 999, 999, 1);
        cycle("999+999_after", 999, 999, 0);

        cycle("800+300", 800, 300, 1);
        cycle("change_no_btn", 5, 5, 0);
        cycle("change_no_btn2", 5, 5, 0);

        cycle("500+0", 500, 0, 1);
        cycle("gap1", 500, 0, 0);
        cycle("0+600", 0, 600, 1);
        cycle("gap2", 0, 600, 0);
        cycle("0+0", 0, 0, 1);
        cycle("gap3", 0, 0, 0);

        cycle("max_carry", 4095, 4095, 1);
        cycle("max_hold", 1, 1, 0);

        // Held press: each edge re-captures with the current operands.
        cycle("hold1", 1, 10, 1);
        cycle("hold2", 2, 10, 1);
        cycle("hold3", 3, 10, 1);
        cycle("hold4", 4, 10, 1);
        // Reset mid-press clears outputs without waiting for a clock.
        assert_reset();
        check_outputs("midhold_rst");
        @(posedge clk); #1 check_outputs("midhold_rst_held");
        rst = 1'b0;
        cycle("resume", 5, 10, 1);
        cycle("release", 6, 10, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            cycle("rand", int'($urandom_range(4095)), int'($urandom_range(4095)),
                  bit'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/suma_aritmetica.md
Name: suma_aritmetica

Overview:
- Registered unsigned adder for the calculator datapath.
- Captures the sum of two 12-bit operands when the sum button (`suma_btn`) is asserted, and holds it until the next capture or reset.
- Sits between the operand entry registers (decimal values 0..999 in binary) and the display/conversion stage.

Parameters:
- ANCHO, 12, operand width in bits; the result is ANCHO+1 bits.

Ports:
- clk  input  1  system clock (27 MHz nominal), rising-edge active
- rst  input  1  reset, asynchronous, active-high
- num1  input  ANCHO  first operand, unsigned binary
- num2  input  ANCHO  second operand, unsigned binary
- suma_btn  input  1  add command, level-sampled, already debounced upstream
- resultado  output  ANCHO+1  registered sum
- listo  output  1  one-cycle pulse: resultado updated this cycle

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-high on rst.
- While rst=1, immediately and asynchronously: resultado=0, listo=0.
- On each rising clk edge with rst=0 and suma_btn=1:
  - resultado <= num1 + num2, zero-extended to ANCHO+1 bits.
  - Full carry is kept; no wrap is possible (max 4095+4095=8190 fits 13 bits).
- On a rising edge with suma_btn=0: resultado holds its value.
- Latency: the new sum is visible on resultado one clock after the sampling edge.
  - Any suma_btn pulse covering at least one rising edge produces a capture.
- Level semantics: suma_btn held for N edges re-captures on every edge.
  - Operand changes during a held press are tracked each cycle.
  - The last sampled pair wins.
- listo:
  - listo <= 1 on every edge where a capture occurs, otherwise 0.
  - For a held button it stays 1 for each capturing cycle.
- No range checking: operands above 999 are summed as plain binary.
- Operand changes while suma_btn=0 have no effect on resultado.
- Reset mid-press: outputs clear immediately. Capture resumes on the first edge after rst deasserts if suma_btn is still 1.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SUMA_BCD_EN.
- Defined:
  - Adds output resultado_bcd, 16 bits: four BCD digits (thousands..units) of resultado.
  - Computed by a combinational binary-to-BCD converter (double-dabble).
  - Registered together with resultado, so it has the same latency and the same reset value (0x0000).
  - Values above 9999 are not produced for ANCHO=12 sums within 0..1998.
  - For larger sums, only the low four BCD digits are output.
- Not defined: the port and converter are absent; all other behaviour is identical.

Test Plan:
- Reset asserted with operands nonzero -> resultado=0, listo=0 immediately, asynchronously; both held while rst=1.
- num1=999, num2=999, suma_btn pulsed one clock -> resultado=1998 one clock later, listo pulses once; with SUMA_BCD_EN, resultado_bcd=0x1998.
- num1=800, num2=300, pulse -> resultado=1100; then change to num1=5, num2=5 with suma_btn=0 -> resultado stays 1100.
- 500+0 -> 500; then 0+600 -> 600; then 0+0 -> 0, each after a one-clock pulse.
- 4095+4095 -> 8190, confirming the carry bit is preserved.
- Hold suma_btn for 3 cycles while num1 steps 1,2,3 and num2=10 -> resultado reads 11, 12, 13; listo=1 for 3 cycles; rst pulsed mid-hold -> 0 immediately, capture resumes after release.
